// File: rtl/pixel_fetch_if.sv
// Signal bundle between the timing controller / framebuffer port and pixel_fetch.
// The fetch unit uses the master view; the surrounding system uses the slave view.
interface pixel_fetch_if;
    logic        H_SYNC;
    logic        V_SYNC;
    logic [2:0]  H_STATUS;
    logic [2:0]  V_STATUS;
    logic [9:0]  PIXEL_CNTR;
    logic [9:0]  ROW_NUM;
    logic        MEM_REQ;
    logic [14:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [7:0]  MEM_DATA;
    logic [2:0]  VGA_R;
    logic [2:0]  VGA_G;
    logic [1:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        UNDERRUN;

    modport master (
        input  H_SYNC, V_SYNC, H_STATUS, V_STATUS, PIXEL_CNTR, ROW_NUM,
        input  MEM_ACK, MEM_DATA,
        output MEM_REQ, MEM_ADDR,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, UNDERRUN
    );

    modport slave (
        output H_SYNC, V_SYNC, H_STATUS, V_STATUS, PIXEL_CNTR, ROW_NUM,
        output MEM_ACK, MEM_DATA,
        input  MEM_REQ, MEM_ADDR,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, UNDERRUN
    );
endinterface

// File: rtl/pixel_fetch.sv
// Line-buffered framebuffer fetch: 160x120 RGB332, each byte a 4x4 block, two line banks
// filled ahead of the scan, with a two-stage output pipeline and a sticky underrun flag.
module pixel_fetch (
    input  logic          CLK,
    input  logic          RST,
    pixel_fetch_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CHAIN} state_t;

    state_t      r_state, w_state_nx;
    logic [6:0]  r_group, w_group_nx;
    logic [7:0]  r_col, w_col_nx;
    logic        r_chain, w_chain_nx;
    logic        r_pend, w_pend_nx;
    logic [6:0]  r_pend_grp, w_pend_grp_nx;
    logic        r_pend_chain, w_pend_chain_nx;
    logic [1:0]  r_valid, w_valid_nx;
    logic        r_underrun, w_under_nx;
    logic        w_start;

    logic        r_vdisp_d;
    logic [9:0]  r_row_d;

    logic [7:0]  r_line [0:1][0:159];

    logic [7:0]  r_s1_data;
    logic        r_s1_show;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic [2:0]  r_vga_r;
    logic [2:0]  r_vga_g;
    logic [1:0]  r_vga_b;
    logic        r_vga_hs;
    logic        r_vga_vs;

    logic        w_frame_trig;
    logic        w_row_chg;
    logic [8:0]  w_row_grp;
    logic        w_row_trig;
    logic        w_trig;
    logic [6:0]  w_trig_grp;
    logic        w_ack;
    logic [14:0] w_addr;
    logic        w_pix_bank;
    logic        w_pix_in;
    logic [7:0]  w_rd_idx;
    logic        w_disp;
    logic        w_pix_under;
    logic        w_unused;

    assign w_frame_trig = r_vdisp_d & ~bus.V_STATUS[2];
    assign w_row_chg    = (bus.ROW_NUM != r_row_d) & bus.V_STATUS[2] & (bus.ROW_NUM[1:0] == 2'b00);
    assign w_row_grp    = {1'b0, bus.ROW_NUM[9:2]} + 9'd1;
    assign w_row_trig   = w_row_chg & (w_row_grp < 9'd120) & ~w_frame_trig;
    assign w_trig       = w_frame_trig | w_row_trig;
    assign w_trig_grp   = w_frame_trig ? 7'd0 : w_row_grp[6:0];
    assign w_ack        = bus.MEM_ACK & (r_state == S_REQ);
    assign w_addr       = 15'(r_group) * 15'd160 + 15'(r_col);

    assign w_pix_bank   = bus.ROW_NUM[2];
    assign w_pix_in     = (bus.PIXEL_CNTR < 10'd640) & (bus.ROW_NUM[9:2] < 8'd120);
    assign w_rd_idx     = w_pix_in ? bus.PIXEL_CNTR[9:2] : 8'd0;
    assign w_disp       = bus.H_STATUS[2] & bus.V_STATUS[2];
    assign w_pix_under  = w_disp & w_pix_in & ~r_valid[w_pix_bank];
    assign w_unused     = ^{bus.H_STATUS[1:0], bus.V_STATUS[1:0]};

    // A trigger is parked in r_pend until the bus is free (idle, chain gap, or the
    // in-flight request's ACK), so MEM_REQ never drops before its handshake completes.
    always_comb begin
        w_state_nx      = r_state;
        w_group_nx      = r_group;
        w_col_nx        = r_col;
        w_chain_nx      = r_chain;
        w_pend_nx       = r_pend;
        w_pend_grp_nx   = r_pend_grp;
        w_pend_chain_nx = r_pend_chain;
        w_valid_nx      = r_valid;
        w_under_nx      = r_underrun | w_pix_under;

        if (w_trig) begin
            w_pend_nx       = 1'b1;
            w_pend_grp_nx   = w_trig_grp;
            w_pend_chain_nx = w_frame_trig;
            if (w_frame_trig) begin
                w_valid_nx = '0;
                w_under_nx = 1'b0;
            end else if (r_state != S_IDLE) begin
                w_under_nx = 1'b1;
            end
        end

        w_start = w_pend_nx & ((r_state != S_REQ) | w_ack);

        if (w_start) begin
            w_state_nx                = S_REQ;
            w_group_nx                = w_pend_grp_nx;
            w_col_nx                  = '0;
            w_chain_nx                = w_pend_chain_nx;
            w_pend_nx                 = 1'b0;
            w_valid_nx[w_pend_grp_nx[0]] = 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_ack) begin
                        if (r_col == 8'd159) begin
                            w_valid_nx[r_group[0]] = 1'b1;
                            w_state_nx = r_chain ? S_CHAIN : S_IDLE;
                        end else begin
                            w_col_nx = r_col + 8'd1;
                        end
                    end
                end
                S_CHAIN: begin
                    w_state_nx    = S_REQ;
                    w_group_nx    = 7'd1;
                    w_col_nx      = '0;
                    w_chain_nx    = 1'b0;
                    w_valid_nx[1] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_group      <= '0;
            r_col        <= '0;
            r_chain      <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_grp   <= '0;
            r_pend_chain <= 1'b0;
            r_valid      <= '0;
            r_underrun   <= 1'b0;
            r_vdisp_d    <= 1'b0;
            r_row_d      <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_group      <= w_group_nx;
            r_col        <= w_col_nx;
            r_chain      <= w_chain_nx;
            r_pend       <= w_pend_nx;
            r_pend_grp   <= w_pend_grp_nx;
            r_pend_chain <= w_pend_chain_nx;
            r_valid      <= w_valid_nx;
            r_underrun   <= w_under_nx;
            r_vdisp_d    <= bus.V_STATUS[2];
            r_row_d      <= bus.ROW_NUM;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_ack) begin
            r_line[r_group[0]][r_col] <= bus.MEM_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_data <= '0;
            r_s1_show <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_vga_r   <= '0;
            r_vga_g   <= '0;
            r_vga_b   <= '0;
            r_vga_hs  <= 1'b1;
            r_vga_vs  <= 1'b1;
        end else begin
            r_s1_data <= r_line[w_pix_bank][w_rd_idx];
            r_s1_show <= w_disp & w_pix_in & r_valid[w_pix_bank];
            r_s1_hs   <= bus.H_SYNC;
            r_s1_vs   <= bus.V_SYNC;
            r_vga_r   <= r_s1_show ? r_s1_data[7:5] : 3'd0;
            r_vga_g   <= r_s1_show ? r_s1_data[4:2] : 3'd0;
            r_vga_b   <= r_s1_show ? r_s1_data[1:0] : 2'd0;
            r_vga_hs  <= r_s1_hs;
            r_vga_vs  <= r_s1_vs;
        end
    end

    assign bus.MEM_REQ  = (r_state == S_REQ);
    assign bus.MEM_ADDR = w_addr;
    assign bus.VGA_R    = r_vga_r;
    assign bus.VGA_G    = r_vga_g;
    assign bus.VGA_B    = r_vga_b;
    assign bus.VGA_HS   = r_vga_hs;
    assign bus.VGA_VS   = r_vga_vs;
    assign bus.UNDERRUN = r_underrun;
endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: framebuffer responder with selectable ACK timing,
// handshake monitor, and hand-computed colour / address expectations.
module tb_pixel_fetch;
    logic CLK;
    logic RST;

    pixel_fetch_if bus ();

    pixel_fetch dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // 0: ACK held low, 1: ACK tied high, 2: ACK on the 6th cycle of each request
    int          ack_mode = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          ack_log [0:399];
    int          ack_cyc [0:399];
    int          req_start = -1;
    int          viol = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_rst = 1'b1;
    logic [14:0] prev_addr = '0;

    function automatic logic [7:0] mem_byte(input logic [14:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd37 + 32'hE3;
        return t[7:0];
    endfunction

    assign bus.MEM_DATA = mem_byte(bus.MEM_ADDR);

    // Responder and monitor run mid-cycle; values seen here are what the DUT samples next edge.
    always @(negedge CLK) begin
        logic req;
        logic ack;
        cyc++;
        req = bus.MEM_REQ;
        if (!req) begin
            wcnt = 0;
            ack  = 1'b0;
        end else if (ack_mode == 1) begin
            ack  = 1'b1;
            wcnt = 0;
        end else if (ack_mode == 2) begin
            wcnt++;
            ack = (wcnt == 6);
            if (ack) wcnt = 0;
        end else begin
            ack = 1'b0;
        end
        bus.MEM_ACK = ack;
        if (prev_req && !prev_ack && !prev_rst) begin
            if (!req || bus.MEM_ADDR != prev_addr) viol++;
        end
        if (req && ack_mode != 0 && req_start < 0) req_start = cyc;
        if (req && ack && !RST && ack_cnt < 400) begin
            ack_log[ack_cnt] = int'(bus.MEM_ADDR);
            ack_cyc[ack_cnt] = cyc;
            ack_cnt++;
        end
        prev_req  = req;
        prev_ack  = ack;
        prev_rst  = RST;
        prev_addr = bus.MEM_ADDR;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        ack_cnt   = 0;
        req_start = -1;
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (ack_cnt < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, ack_cnt, n);
    endtask

    task automatic seq_check(input int base, input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (ack_log[i] != base + i) bad++;
        end
        check(tag, bad, 0);
    endtask

    function automatic logic [7:0] rgb();
        return {bus.VGA_R, bus.VGA_G, bus.VGA_B};
    endfunction

    initial begin
        RST = 1'b1;
        bus.H_SYNC = 1'b0;
        bus.V_SYNC = 1'b0;
        bus.H_STATUS = 3'd0;
        bus.V_STATUS = 3'd0;
        bus.PIXEL_CNTR = 10'd0;
        bus.ROW_NUM = 10'd0;

        // reset values
        tick();
        tick();
        check("rst_req", bus.MEM_REQ, 0);
        check("rst_addr", bus.MEM_ADDR, 0);
        check("rst_under", bus.UNDERRUN, 0);
        check("rst_rgb", rgb(), 0);
        check("rst_hs", bus.VGA_HS, 1);
        check("rst_vs", bus.VGA_VS, 1);
        bus.H_SYNC = 1'b1;
        bus.V_SYNC = 1'b1;
        RST = 1'b0;

        // frame trigger, ACK tied high: 320 sequential bytes
        ack_mode = 1;
        bus.V_STATUS = 3'b100;
        tick();
        clear_log();
        bus.V_STATUS = 3'b000;
        tick();
        wait_acks(320, 1000, "frame_acks");
        seq_check(0, 320, "frame_addr_seq");
        tick();
        check("frame_req_low", bus.MEM_REQ, 0);
        check("frame_under", bus.UNDERRUN, 0);

        // colour decode and 4x4 replication of byte 0 (0xE3), sync delay
        bus.H_STATUS = 3'b100;
        bus.V_STATUS = 3'b100;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned p = 0; p < 4; p++) begin
                bus.ROW_NUM = 10'(r);
                bus.PIXEL_CNTR = 10'(p);
                bus.H_SYNC = !(r == 0 && p == 0);
                bus.V_SYNC = !(r == 0 && p == 0);
                tick();
                if (r == 0 && p == 0) begin
                    check("hs_d1", bus.VGA_HS, 1);
                    check("vs_d1", bus.VGA_VS, 1);
                end
                bus.H_SYNC = 1'b1;
                bus.V_SYNC = 1'b1;
                tick();
                if (r == 0 && p == 0) begin
                    check("hs_d2", bus.VGA_HS, 0);
                    check("vs_d2", bus.VGA_VS, 0);
                end
                check("pix_e3", rgb(), 8'hE3);
            end
        end
        tick();
        check("hs_back", bus.VGA_HS, 1);

        // row 4 (group 1) while group 2 fetches into the other bank
        clear_log();
        bus.ROW_NUM = 10'd4;
        bus.PIXEL_CNTR = 10'd20;
        tick();
        tick();
        check("pix_g1c5", rgb(), mem_byte(15'd165));
        bus.PIXEL_CNTR = 10'd640;
        tick();
        tick();
        check("pix_col640", rgb(), 0);
        bus.PIXEL_CNTR = 10'd20;
        bus.H_STATUS = 3'b000;
        tick();
        tick();
        check("pix_nodisp", rgb(), 0);
        check("row_under", bus.UNDERRUN, 0);
        wait_acks(160, 400, "row4_acks");
        seq_check(320, 160, "row4_addr_seq");

        // slow ACK: 6 cycles per byte, row 8 fetches group 3
        tick();
        ack_mode = 2;
        clear_log();
        bus.ROW_NUM = 10'd8;
        tick();
        wait_acks(160, 1200, "slow_acks");
        seq_check(480, 160, "slow_addr_seq");
        check("slow_cycles", ack_cyc[159] - req_start + 1, 960);
        tick();
        check("slow_req_low", bus.MEM_REQ, 0);
        check("slow_under", bus.UNDERRUN, 0);

        // row trigger while a fetch is stalled
        ack_mode = 0;
        bus.V_STATUS = 3'b000;
        bus.ROW_NUM = 10'd0;
        tick();
        bus.V_STATUS = 3'b100;
        bus.ROW_NUM = 10'd3;
        tick();
        check("busy_req", bus.MEM_REQ, 1);
        bus.ROW_NUM = 10'd4;
        tick();
        check("busy_under", bus.UNDERRUN, 1);
        check("busy_addr_hold", bus.MEM_ADDR, 0);
        check("busy_req_hold", bus.MEM_REQ, 1);
        clear_log();
        ack_mode = 1;
        tick();
        ack_mode = 0;
        check("busy_ack_cnt", ack_cnt, 1);
        check("busy_ack_addr", ack_log[0], 0);
        check("busy_next_addr", bus.MEM_ADDR, 320);
        check("busy_next_req", bus.MEM_REQ, 1);

        // ACK starved: frame trigger clears flag, first display pixel sets it, next frame clears it
        bus.V_STATUS = 3'b000;
        bus.ROW_NUM = 10'd0;
        tick();
        check("starve_frame_clr", bus.UNDERRUN, 0);
        bus.H_STATUS = 3'b100;
        bus.V_STATUS = 3'b100;
        bus.PIXEL_CNTR = 10'd0;
        tick();
        check("starve_under", bus.UNDERRUN, 1);
        tick();
        check("starve_black", rgb(), 0);
        bus.H_STATUS = 3'b000;
        bus.V_STATUS = 3'b000;
        tick();
        check("starve_next_clr", bus.UNDERRUN, 0);

        // release ACK: stalled byte completes, then the pending frame fetch runs
        clear_log();
        ack_mode = 1;
        wait_acks(321, 1000, "resume_acks");
        check("resume_first", ack_log[0], 320);
        check("resume_last", ack_log[320], 319);
        tick();
        check("resume_req_low", bus.MEM_REQ, 0);

        // reset in the middle of a fetch
        bus.H_STATUS = 3'b100;
        bus.V_STATUS = 3'b100;
        bus.PIXEL_CNTR = 10'd20;
        bus.ROW_NUM = 10'd4;
        for (int unsigned i = 0; i < 5; i++) tick();
        bus.ROW_NUM = 10'd12;
        tick();
        bus.ROW_NUM = 10'd5;
        tick();
        tick();
        check("mid_under", bus.UNDERRUN, 1);
        check("mid_rgb", rgb(), mem_byte(15'd165));
        check("mid_req", bus.MEM_REQ, 1);
        RST = 1'b1;
        bus.ROW_NUM = 10'd0;
        tick();
        check("rstmid_req", bus.MEM_REQ, 0);
        check("rstmid_rgb", rgb(), 0);
        check("rstmid_under", bus.UNDERRUN, 0);
        RST = 1'b0;
        bus.H_STATUS = 3'b000;
        bus.PIXEL_CNTR = 10'd0;
        tick();
        check("rstmid_idle", bus.MEM_REQ, 0);
        clear_log();
        bus.V_STATUS = 3'b000;
        tick();
        wait_acks(320, 1000, "post_rst_acks");
        seq_check(0, 320, "post_rst_seq");
        tick();
        check("post_rst_req_low", bus.MEM_REQ, 0);
        check("handshake_stable", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 CLK  in  1  pixel clock; all state changes on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 H_SYNC, V_SYNC  in  1 each  raw syncs from the timing controller.
REQ-004 H_STATUS, V_STATUS  in  3 each  zone codes; bit 2 = display zone.
REQ-005 PIXEL_CNTR  in  10  column within the display zone.
REQ-006 ROW_NUM  in  10  row within the display zone; 0 outside it.
REQ-007 MEM_REQ  out  1  framebuffer read request.
REQ-008 MEM_ADDR  out  15  byte address, group*160 + col.
REQ-009 MEM_ACK  in  1  request accepted; MEM_DATA valid in the same cycle.
REQ-010 MEM_DATA  in  8  RGB332 pixel byte: [7:5] R, [4:2] G, [1:0] B.
REQ-011 VGA_R, VGA_G, VGA_B  out  3/3/2  pixel colour.
REQ-012 VGA_HS, VGA_VS  out  1 each  delayed syncs.
REQ-013 UNDERRUN  out  1  sticky per-frame error flag.

Function
REQ-014 Framebuffer is 160x120 RGB332; each byte covers a 4x4 screen block; group = ROW_NUM[9:2], col = PIXEL_CNTR[9:2].
REQ-015 Two 160-byte line banks; group g is stored in bank g[0]; each bank has a valid bit.
REQ-016 Frame trigger: V_STATUS[2] falling 1->0 (registered edge detect); on it, clear UNDERRUN, clear both valid bits, and fetch group 0 then group 1 back to back.
REQ-017 Row trigger: ROW_NUM differs from its value the previous cycle, V_STATUS[2]=1, and new ROW_NUM[1:0]=0.
REQ-018 On a row trigger, fetch group g+1, where g = new ROW_NUM[9:2]; if g+1 >= 120, no fetch.
REQ-019 FSM states: IDLE, REQ, CHAIN. IDLE -> REQ on a trigger. REQ -> CHAIN on the ACK of the 160th byte of group 0 from a frame trigger. REQ -> IDLE on the ACK of the 160th byte otherwise. CHAIN -> REQ next cycle with group 1.
REQ-020 Starting a fetch into a bank clears that bank's valid bit; the ACK of byte 159 sets it.
REQ-021 Handshake: MEM_REQ and MEM_ADDR are held stable until MEM_ACK is sampled high. One outstanding request at a time. After an ACK, the next request may assert in the following cycle.
REQ-022 MEM_DATA is written to bank[col] on each ACK cycle; col counts 0..159, and MEM_ADDR = group*160 + col.
REQ-023 Trigger while not IDLE:
  - set UNDERRUN;
  - the pending request completes its handshake;
  - the fetch then restarts at col 0 for the new trigger's group.
  - MEM_REQ never drops without an ACK.
REQ-024 Output pipeline is 2 cycles.
  - Cycle 1: register the bank read, the display flag (H_STATUS[2] & V_STATUS[2]), H_SYNC and V_SYNC.
  - Cycle 2: register the outputs.
  - VGA_HS and VGA_VS equal H_SYNC and V_SYNC delayed by exactly 2 cycles.
REQ-025 RGB is 0 when any of these holds: the delayed display flag is 0; PIXEL_CNTR >= 640; group >= 120; the addressed bank is not valid.
REQ-026 A display-zone pixel whose group < 120, PIXEL_CNTR < 640 and bank not valid sets UNDERRUN.
REQ-027 UNDERRUN stays set until the next frame trigger or reset.
REQ-028 A simultaneous frame trigger and row trigger are resolved in favour of the frame trigger.

Reset
REQ-029 While RST=1 at a clock edge:
  - FSM <= IDLE, MEM_REQ <= 0, MEM_ADDR <= 0;
  - valid bits <= 0, UNDERRUN <= 0;
  - RGB <= 0, VGA_HS <= 1, VGA_VS <= 1;
  - edge-detect registers <= 0.
REQ-030 RST asserted mid-fetch abandons the request immediately. Bank contents are don't-care; the valid bits gate their use.

Verification
REQ-031 Frame trigger with MEM_ACK tied 1 -> 320 consecutive ACKs, addresses 0..319, bank0 and bank1 valid, MEM_REQ low afterwards.
REQ-032 Byte 0xE3 at address 0, display pixel (0,0) -> 2 cycles later VGA_R=7, VGA_G=0, VGA_B=3; the same colour holds for PIXEL_CNTR 0..3 and rows 0..3.
REQ-033 MEM_ACK delayed 5 cycles per request -> MEM_REQ and MEM_ADDR stay stable throughout; no byte skipped; fetch completes after 960 cycles.
REQ-034 MEM_ACK held 0 after a frame trigger -> black output in the display zone; UNDERRUN=1 on the first display pixel; UNDERRUN cleared by the next frame trigger.
REQ-035 ROW_NUM 3->4 with a fetch still busy -> UNDERRUN=1; the current handshake completes; the next address is 2*160 = 320.
REQ-036 RST pulse in the middle of a fetch -> next cycle MEM_REQ=0, RGB=0, UNDERRUN=0; a normal fetch follows the next frame trigger.
